hpdcache_dir_arbiter: RTL

Shares the single directory port of the HPDcache memory array among several requesters (miss handler refill, core request pipeline, flush/CMO unit). After reset it first sweeps every directory set and writes all ways to zero, so all lines start invalid; only then does it grant requesters. It sits between the cache controller units and the directory inputs of the memory array, and it returns read entries tagged with the requester ID.

---
 rtl/hpdcache_pkg.sv | 36 +++
 rtl/hpdcache_dir_rrarb.sv | 59 +++++
 rtl/hpdcache_dir_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/hpdcache_pkg.sv
// rtl/hpdcache_pkg.sv - HPDcache shared directory types and directory arbiter constants
package hpdcache_pkg;

  localparam int unsigned HPDCACHE_WAYS               = 4;
  localparam int unsigned HPDCACHE_DIR_RAM_ADDR_WIDTH = 6;
  localparam int unsigned HPDCACHE_DIR_SETS           = 2 ** HPDCACHE_DIR_RAM_ADDR_WIDTH;
  localparam int unsigned HPDCACHE_TAG_WIDTH          = 20;
  localparam int unsigned HPDCACHE_DIR_ARB_NREQ       = 3;

  typedef logic [HPDCACHE_DIR_RAM_ADDR_WIDTH-1:0] hpdcache_dir_addr_t;
  typedef logic [HPDCACHE_WAYS-1:0]               hpdcache_way_vector_t;

  typedef struct packed {
    logic                          valid;
    logic                          wback;
    logic                          dirty;
    logic                          fetch;
    logic [HPDCACHE_TAG_WIDTH-1:0] tag;
  } hpdcache_dir_entry_t;

  // One entry per way, as presented on the directory port of the memory array
  typedef hpdcache_dir_entry_t [HPDCACHE_WAYS-1:0] hpdcache_dir_way_entries_t;

  typedef struct packed {
    hpdcache_dir_addr_t        addr;
    hpdcache_way_vector_t      way;
    logic                      we;
    hpdcache_dir_way_entries_t wentry;
  } hpdcache_dir_req_t;

  typedef enum logic {
    DIR_ARB_INIT = 1'b0,
    DIR_ARB_RUN  = 1'b1
  } hpdcache_dir_arb_state_e;

endpackage

// File: rtl/hpdcache_dir_rrarb.sv
// rtl/hpdcache_dir_rrarb.sv - one-hot picker, round-robin when HPDCACHE_DIR_ARB_RR_EN is defined, else fixed priority
module hpdcache_dir_rrarb #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
`ifdef HPDCACHE_DIR_ARB_RR_EN
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            hs_i,
`endif
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_id_o
);

  logic [IDW-1:0] ptr;
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;
  logic           found;

`ifdef HPDCACHE_DIR_ARB_RR_EN
  logic [IDW-1:0] ptr_next;

  assign ptr_next = (gnt_id_o == IDW'(NREQ - 1)) ? '0 : gnt_id_o + 1'b1;

  // Priority pointer moves just past the winner whenever a grant is taken
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr <= '0;
    end else if (hs_i) begin
      ptr <= ptr_next;
    end
  end
`else
  assign ptr = '0;
`endif

  // Scan requesters starting at the pointer, wrapping modulo NREQ; first valid wins
  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (IDW + 1)'(i);
      if (sum >= (IDW + 1)'(NREQ)) begin
        sum = sum - (IDW + 1)'(NREQ);
      end
      idx = sum[IDW-1:0];
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = idx;
      end
    end
  end

endmodule

// File: rtl/hpdcache_dir_arbiter.sv
// rtl/hpdcache_dir_arbiter.sv - directory port arbiter with reset-time invalidation sweep; HPDCACHE_DIR_ARB_RR_EN selects round-robin
module hpdcache_dir_arbiter
  import hpdcache_pkg::*;
#(
  parameter int unsigned NREQ = HPDCACHE_DIR_ARB_NREQ,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NREQ-1:0]           req_valid_i,
  output logic [NREQ-1:0]           req_ready_o,
  input  hpdcache_dir_addr_t        req_addr_i   [NREQ],
  input  hpdcache_way_vector_t      req_way_i    [NREQ],
  input  logic [NREQ-1:0]           req_we_i,
  input  hpdcache_dir_way_entries_t req_wentry_i [NREQ],
  output hpdcache_dir_addr_t        dir_addr_o,
  output hpdcache_way_vector_t      dir_cs_o,
  output hpdcache_way_vector_t      dir_we_o,
  output hpdcache_dir_way_entries_t dir_wentry_o,
  input  hpdcache_dir_way_entries_t dir_rentry_i,
  output logic                      rsp_valid_o,
  output logic [IDW-1:0]            rsp_id_o,
  output hpdcache_dir_way_entries_t rsp_entry_o,
  output logic                      init_done_o
);

  localparam int unsigned NSETS = HPDCACHE_DIR_SETS;

  hpdcache_dir_arb_state_e state_q, state_d;
  hpdcache_dir_addr_t      cnt_q, cnt_d;
  logic                    rsp_valid_q;
  logic [IDW-1:0]          rsp_id_q;

  logic [NREQ-1:0]         arb_req;
  logic [NREQ-1:0]         gnt;
  logic [IDW-1:0]          gnt_id;
  logic                    hs;
  hpdcache_dir_req_t       sel;

  // Requesters are invisible to the picker until the sweep has finished
  assign arb_req = (state_q == DIR_ARB_RUN) ? req_valid_i : '0;
  assign hs      = |gnt;

  hpdcache_dir_rrarb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) i_rrarb (
`ifdef HPDCACHE_DIR_ARB_RR_EN
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .hs_i     (hs),
`endif
    .req_i    (arb_req),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  // Gather the winning requester's fields into one directory request
  always_comb begin
    sel.addr   = req_addr_i[gnt_id];
    sel.way    = req_way_i[gnt_id];
    sel.we     = req_we_i[gnt_id];
    sel.wentry = req_wentry_i[gnt_id];
  end

  // Next state and directory port drive: sweep writes zeros, then pass the winner through
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_o  = '0;
    dir_addr_o   = '0;
    dir_cs_o     = '0;
    dir_we_o     = '0;
    dir_wentry_o = '0;
    case (state_q)
      DIR_ARB_INIT: begin
        dir_addr_o = cnt_q;
        dir_cs_o   = '1;
        dir_we_o   = '1;
        if (cnt_q == hpdcache_dir_addr_t'(NSETS - 1)) begin
          state_d = DIR_ARB_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DIR_ARB_RUN: begin
        req_ready_o = gnt;
        if (hs) begin
          dir_addr_o   = sel.addr;
          dir_cs_o     = sel.way;
          dir_we_o     = sel.we ? sel.way : '0;
          dir_wentry_o = sel.wentry;
        end
      end
      default: begin
        state_d = DIR_ARB_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // State, sweep counter and read-response tag registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= DIR_ARB_INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= hs && !sel.we;
      rsp_id_q    <= gnt_id;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_entry_o = dir_rentry_i;
  assign init_done_o = (state_q == DIR_ARB_RUN);

endmodule
